// File: rtl/rr_arbiter_8_pkg.sv
// Shared constants and state encoding for the eight-way round-robin arbiter.
package arb_pkg;
  localparam int ARB_N     = 8;
  localparam int ARB_IDX_W = 3;

  typedef enum logic {
    ARB_IDLE,
    ARB_GRANT
  } arb_state_e;
endpackage

// File: rtl/rr_arbiter_8_if.sv
// Request/grant bundle between the requesters (master) and the arbiter (slave).
interface rr_arbiter_8_if;
  import arb_pkg::*;

  logic [ARB_N-1:0]     req;
  logic                 done;
  logic [ARB_N-1:0]     gnt;
  logic [ARB_IDX_W-1:0] gnt_idx;
  logic                 gnt_vld;
  logic                 timeout;

  modport master (output req, done, input gnt, gnt_idx, gnt_vld, timeout);
  modport slave  (input req, done, output gnt, gnt_idx, gnt_vld, timeout);
endinterface

// File: rtl/rr_arbiter_8_grant_decoder.sv
// Enabled 3-to-8 one-hot decoder; all outputs low when disabled.
module grant_decoder
  import arb_pkg::*;
(
  input  logic [ARB_IDX_W-1:0] idx_i,
  input  logic                 en_i,
  output logic [ARB_N-1:0]     gnt_o
);
  for (genvar gi = 0; gi < ARB_N; gi++) begin : g_dec
    assign gnt_o[gi] = en_i && (idx_i == ARB_IDX_W'(gi));
  end
endmodule

// File: rtl/rr_arbiter_8.sv
// Eight-way round-robin arbiter with a per-grant hold limit and timeout pulse.
module rr_arbiter_8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 16
) (
  input logic           clk,
  input logic           rst,
  rr_arbiter_8_if.slave bus
);
  localparam int HOLD_W = $clog2(MAX_HOLD);

  arb_state_e           state_q;
  logic [ARB_IDX_W-1:0] ptr_q;
  logic [ARB_IDX_W-1:0] gnt_idx_q;
  logic                 gnt_vld_q;
  logic                 timeout_q;
  logic [HOLD_W-1:0]    hold_cnt_q;
  logic [ARB_N-1:0]     gnt_w;

  // First set request at or above p, wrapping from 7 back to 0.
  function automatic logic [ARB_IDX_W-1:0] rr_pick(input logic [ARB_N-1:0] r,
                                                   input logic [ARB_IDX_W-1:0] p);
    logic [ARB_IDX_W-1:0] idx;
    logic                 found;
    rr_pick = p;
    found   = 1'b0;
    for (int k = 0; k < ARB_N; k++) begin
      idx = p + ARB_IDX_W'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  logic rel_done, rel_drop, rel_hold;
  assign rel_done = bus.done;
  assign rel_drop = !bus.req[gnt_idx_q];
  assign rel_hold = (hold_cnt_q == HOLD_W'(MAX_HOLD - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      ptr_q      <= '0;
      gnt_idx_q  <= '0;
      gnt_vld_q  <= 1'b0;
      timeout_q  <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      case (state_q)
        ARB_IDLE: begin
          timeout_q <= 1'b0;
          if (bus.req != '0) begin
            gnt_idx_q  <= rr_pick(bus.req, ptr_q);
            gnt_vld_q  <= 1'b1;
            hold_cnt_q <= '0;
            state_q    <= ARB_GRANT;
          end
        end
        ARB_GRANT: begin
          if (rel_done || rel_drop || rel_hold) begin
            state_q   <= ARB_IDLE;
            gnt_vld_q <= 1'b0;
            ptr_q     <= gnt_idx_q + 1'b1;
            // Only a pure hold-limit release counts as a timeout.
            timeout_q <= rel_hold && !rel_done && !rel_drop;
          end else begin
            hold_cnt_q <= hold_cnt_q + 1'b1;
          end
        end
        default: state_q <= ARB_IDLE;
      endcase
    end
  end

  grant_decoder u_dec (
    .idx_i (gnt_idx_q),
    .en_i  (gnt_vld_q),
    .gnt_o (gnt_w)
  );

  assign bus.gnt     = gnt_w;
  assign bus.gnt_idx = gnt_idx_q;
  assign bus.gnt_vld = gnt_vld_q;
  assign bus.timeout = timeout_q;
endmodule

// File: tb/tb_rr_arbiter_8.sv
// Directed bench for rr_arbiter_8 with a short hold limit of 4 cycles.
module tb_rr_arbiter_8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   vectors = 0;
  int   miscompares = 0;

  rr_arbiter_8_if bus ();

  rr_arbiter_8 #(.MAX_HOLD(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
      $display("ok   %s obs=%h exp=%h", tag, obs, exp);
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_grant(input string tag, input logic [2:0] idx);
    check({tag, " gnt"}, bus.gnt, 8'h01 << idx);
    check({tag, " idx"}, {5'd0, bus.gnt_idx}, {5'd0, idx});
    check({tag, " vld"}, {7'd0, bus.gnt_vld}, 8'h01);
    check({tag, " to"}, {7'd0, bus.timeout}, 8'h00);
  endtask

  task automatic check_idle(input string tag, input logic [2:0] idx, input logic to);
    check({tag, " gnt"}, bus.gnt, 8'h00);
    check({tag, " idx"}, {5'd0, bus.gnt_idx}, {5'd0, idx});
    check({tag, " vld"}, {7'd0, bus.gnt_vld}, 8'h00);
    check({tag, " to"}, {7'd0, bus.timeout}, {7'd0, to});
  endtask

  initial begin
    bus.req  = 8'h00;
    bus.done = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_idle("reset", 3'd0, 1'b0);
    rst = 1'b0;

    // Single requester 2, done during the third grant cycle.
    bus.req = 8'h04;
    step(); check_grant("single c1", 3'd2);
    step(); check_grant("single c2", 3'd2);
    step(); check_grant("single c3", 3'd2);
    bus.done = 1'b1;
    step(); check_idle("single rel", 3'd2, 1'b0);
    bus.done = 1'b0;
    step(); check_grant("single regrant", 3'd2);
    bus.req = 8'h00;
    step(); check_idle("single drop", 3'd2, 1'b0);

    // Full load from a fresh pointer of 0.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      step(); check_grant($sformatf("full g%0d", g), 3'(g % 8));
      bus.done = 1'b1;
      step(); check_idle($sformatf("full d%0d", g), 3'(g % 8), 1'b0);
      bus.done = 1'b0;
    end

    // Hold-limit timeout: ptr is 1, so search wraps to requester 0.
    bus.req = 8'h01;
    for (int c = 1; c <= 4; c++) begin
      step(); check_grant($sformatf("hold c%0d", c), 3'd0);
    end
    step(); check_idle("hold timeout", 3'd0, 1'b1);
    step(); check_grant("hold regrant", 3'd0);

    // done coinciding with the last allowed cycle suppresses timeout.
    step(); check_grant("simul c2", 3'd0);
    step(); check_grant("simul c3", 3'd0);
    step(); check_grant("simul c4", 3'd0);
    bus.done = 1'b1;
    step(); check_idle("simul rel", 3'd0, 1'b0);
    bus.done = 1'b0;
    bus.req  = 8'h00;
    step(); check_idle("simul after", 3'd0, 1'b0);

    // Request drop on index 6, then wrap from ptr 7 to requester 0.
    bus.req = 8'h41;
    step(); check_grant("wrap g6", 3'd6);
    bus.req = 8'h01;
    step(); check_idle("wrap drop", 3'd6, 1'b0);
    step(); check_grant("wrap g0", 3'd0);
    bus.req = 8'h00;
    step(); check_idle("wrap end", 3'd0, 1'b0);

    // Asynchronous reset in the middle of a grant to requester 5.
    bus.req = 8'h20;
    step(); check_grant("rst pre", 3'd5);
    rst = 1'b1;
    #1;
    check_idle("rst async", 3'd0, 1'b0);
    bus.req = 8'h21;
    @(negedge clk);
    check_idle("rst held", 3'd0, 1'b0);
    rst = 1'b0;
    step(); check_grant("rst regrant", 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/rr_arbiter_8.md
# rr_arbiter_8

Eight-way round-robin arbiter that shares one downstream resource, such as a bus port or a datapath slot, among eight requesters. It registers a 3-bit grant index and decodes it to a one-hot grant vector. It also enforces a maximum hold time per grant. A granted requester releases the resource by asserting `done`, by dropping its request, or by being forced off at timeout.

## Interface
Parameters:
- `MAX_HOLD`, default 16: maximum number of consecutive cycles one grant may last. Legal range 2..256.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req`  in  8  request vector; bit i is requester i. Level-sensitive.
- `done`  in  1  release strobe from the currently granted requester. Ignored when `gnt_vld` = 0.
- `gnt`  out  8  one-hot grant. All zero when `gnt_vld` = 0.
- `gnt_idx`  out  3  binary index of the current or last grantee.
- `gnt_vld`  out  1  a grant is active.
- `timeout`  out  1  one-cycle pulse when a grant is forcibly ended by `MAX_HOLD`.

## Operation
- State machine has two states:
  - IDLE: no grant active.
  - GRANT: one requester holds the resource.
- Round-robin pointer `ptr` (3 bits) gives the highest-priority index. Priority then descends `ptr`, `ptr+1`, … `ptr+7`, mod 8.
- IDLE, `req` ≠ 0:
  - Select the first set bit searching upward from `ptr`, with wrap-around from 7 to 0.
  - Load `gnt_idx` with it, set `gnt_vld` = 1, clear `hold_cnt` to 0, go to GRANT.
- IDLE, `req` = 0: stay in IDLE; all outputs hold.
- GRANT: release at the next edge, returning to IDLE with `gnt_vld` = 0 and `ptr` = `gnt_idx`+1 mod 8, when any of these is true:
  - (a) `done` = 1;
  - (b) `req[gnt_idx]` = 0;
  - (c) `hold_cnt` = `MAX_HOLD`-1.
- Otherwise in GRANT, `hold_cnt` increments by 1.
- `timeout` = 1 for exactly one cycle, coincident with the first IDLE cycle, only when (c) is the sole release cause. If (a) or (b) also holds, `timeout` stays 0.
- `gnt` = one-hot decode of `gnt_idx`, gated by `gnt_vld`. It is combinational from registered state, so it is glitch-free with respect to the inputs.
- `gnt_idx` retains the last grantee while in IDLE.
- `hold_cnt` width is $clog2(`MAX_HOLD`). It never exceeds `MAX_HOLD`-1.
- Reset (asynchronous, any state, including mid-grant) forces:
  - state = IDLE, `ptr` = 0, `gnt_idx` = 0, `hold_cnt` = 0;
  - `gnt_vld` = 0, `gnt` = 8'h00, `timeout` = 0.
- After `rst` deasserts, the first arbitration uses `ptr` = 0.

## Timing
- Request-to-grant latency: `req` sampled at edge N while in IDLE gives `gnt_vld` = 1 after edge N.
- A grant lasts at least 1 and at most `MAX_HOLD` cycles.
- Release: `done` or a `req` drop sampled at edge N gives `gnt_vld` = 0 after edge N.
- Exactly one dead (IDLE) cycle separates consecutive grants. Sustained full load therefore reaches at most `MAX_HOLD`/(`MAX_HOLD`+1) utilisation.
- Fairness: under continuous requests from k requesters, each is granted once every k grants.
- The `req` and `done` values present during the dead cycle are the ones used for the next arbitration.

## Structure
- Shared package `arb_pkg` holds:
  - `ARB_N` = 8 and `ARB_IDX_W` = 3;
  - the state typedef (`ARB_IDLE`, `ARB_GRANT`).
- Sub-module `grant_decoder` is an enabled 3-to-8 one-hot decoder: input index plus enable, output 8 bits, all zero when disabled. It produces `gnt` from `gnt_idx` and `gnt_vld`.
- The rotating priority search is a combinational function in the top module.

## Test plan
- Single requester: `req` = 8'h04, `done` at the 3rd grant cycle. Expect `gnt` = 8'h04 and `gnt_idx` = 2 for 3 cycles, then `gnt` = 0, then a regrant after one dead cycle with `ptr` = 3.
- Full load: `req` = 8'hFF, `done` pulsed every grant. Expect grant order 0,1,2,…,7,0 with a dead cycle between each.
- Timeout: `MAX_HOLD` = 4, `req` = 8'h01 held, no `done`. Expect `gnt_vld` high for exactly 4 cycles, then `timeout` = 1 for one cycle, then a regrant to 0.
- Simultaneous release: `MAX_HOLD` = 4, `done` asserted on the 4th cycle. Expect release with `timeout` = 0.
- Request drop plus wrap: grant index 6, then `req` changes from 8'h41 to 8'h01. Expect release next edge, then grant to 0 (wrap search from `ptr` = 7).
- Reset mid-grant: `rst` pulsed while `gnt` = 8'h20. Expect `gnt`, `gnt_vld`, `gnt_idx` and `timeout` to be 0 immediately. After release with `req` = 8'h21, expect grant to 0.
